voice_allocator: RTL and testbench

//   Schedules MIDI note events onto the VOICES shared synth_engine voice slots.

---
 rtl/voice_allocator.sv | 192 +++++++++++++++++++
 tb/tb_voice_allocator.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: maps MIDI note events onto VOICES synth_engine voice slots.
// Each event walks IDLE -> LOOKUP -> ISSUE. The voice is chosen in LOOKUP.
// All engine-facing outputs are registered on the LOOKUP->ISSUE edge, so they
// are visible during the ISSUE cycle.
// Optional feature macro: VOICE_STEAL_EN. When it is defined and no voice is
// free, the oldest voice (LRU rank VOICES-1) is stolen. When it is undefined,
// such a note-on is dropped.
//
// ev_valid/ev_ready: an event transfers on a rising edge where both are 1.
// ev_on/ev_key/ev_vel must be stable while ev_valid is 1. ev_ready does not
// depend on ev_valid.
module voice_allocator #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3
) (
  input  logic               OSC_CLK,
  input  logic               reset_reg_N,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic               ev_on,
  input  logic [7:0]         ev_key,
  input  logic [7:0]         ev_vel,
  input  logic               all_off,
  input  logic [VOICES-1:0]  voice_free,
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off,
  output logic               voice_stolen,
  output logic [1:0]         fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOOKUP = 2'd1, ISSUE = 2'd2} state_t;

  localparam logic [V_WIDTH-1:0] OLDEST = V_WIDTH'(VOICES - 1);

  state_t             state;
  state_t             state_nxt;
  logic               lat_on;
  logic [7:0]         lat_key;
  logic [7:0]         lat_vel;
  logic [7:0]         key_tab [VOICES];
  logic [V_WIDTH-1:0] rank    [VOICES];

  logic               match_hit;
  logic [V_WIDTH-1:0] match_v;
  logic               free_hit;
  logic [V_WIDTH-1:0] free_v;
  logic               sel_hit;
  logic [V_WIDTH-1:0] sel_v;
  logic               sel_steal;
  logic               accept;

  assign accept = ev_valid && ev_ready;

  // Voice search. The scan runs from high to low, so the lowest index wins.
`ifdef VOICE_STEAL_EN
  logic [V_WIDTH-1:0] old_v;
  always_comb begin
    old_v = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (rank[i] == OLDEST) old_v = V_WIDTH'(i);
    end
  end
`endif

  // Finds the lowest held voice with the latched key, and the lowest free voice.
  always_comb begin
    match_hit = 1'b0;
    match_v   = '0;
    free_hit  = 1'b0;
    free_v    = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (keys_on[i] && key_tab[i] == lat_key) begin
        match_hit = 1'b1;
        match_v   = V_WIDTH'(i);
      end
      if (!keys_on[i] && voice_free[i]) begin
        free_hit = 1'b1;
        free_v   = V_WIDTH'(i);
      end
    end
  end

  // Selection priority: retrigger, then free voice, then steal (if enabled).
  // A note-off only ever matches a held voice.
  always_comb begin
    sel_hit   = 1'b0;
    sel_v     = '0;
    sel_steal = 1'b0;
    if (match_hit) begin
      sel_hit = 1'b1;
      sel_v   = match_v;
    end else if (lat_on && free_hit) begin
      sel_hit = 1'b1;
      sel_v   = free_v;
    end else if (lat_on) begin
`ifdef VOICE_STEAL_EN
      sel_hit   = 1'b1;
      sel_v     = old_v;
      sel_steal = 1'b1;
`endif
    end
  end

  // State register.
  always_ff @(posedge OSC_CLK) begin
    if (!reset_reg_N) state <= IDLE;
    else              state <= state_nxt;
  end

  // Next-state logic. all_off always forces the FSM back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = sel_hit ? ISSUE : IDLE;
      ISSUE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (all_off) state_nxt = IDLE;
  end

  // FSM outputs: handshake ready and state visibility.
  always_comb begin
    ev_ready  = (state == IDLE) && !all_off;
    fsm_state = state;
  end

  // Datapath: event latch, voice tables, LRU ranks and engine outputs.
  always_ff @(posedge OSC_CLK) begin
    if (!reset_reg_N) begin
      lat_on      <= 1'b0;
      lat_key     <= '0;
      lat_vel     <= '0;
      keys_on     <= '0;
      note_on     <= 1'b0;
      cur_key_adr <= '0;
      cur_key_val <= '0;
      cur_vel_on  <= '0;
      cur_vel_off <= '0;
      for (int i = 0; i < VOICES; i++) begin
        key_tab[i] <= '0;
        rank[i]    <= V_WIDTH'(VOICES - 1 - i);
      end
    end else begin
      note_on <= 1'b0;
      if (all_off) begin
        keys_on <= '0;
      end else begin
        if (state == IDLE && accept) begin
          // A note-on with zero velocity is treated as a note-off.
          lat_on  <= ev_on && (ev_vel != 8'd0);
          lat_key <= ev_key;
          lat_vel <= ev_vel;
        end
        if (state == LOOKUP && sel_hit) begin
          cur_key_adr <= sel_v;
          cur_key_val <= lat_key;
          if (lat_on) begin
            note_on          <= 1'b1;
            cur_vel_on       <= lat_vel;
            keys_on[sel_v]   <= 1'b1;
            key_tab[sel_v]   <= lat_key;
            // Voices younger than the selected one age by one step. The
            // selected voice becomes the youngest. This keeps rank a permutation.
            for (int j = 0; j < VOICES; j++) begin
              if (rank[j] < rank[sel_v]) rank[j] <= rank[j] + V_WIDTH'(1);
            end
            rank[sel_v] <= '0;
          end else begin
            keys_on[sel_v] <= 1'b0;
            cur_vel_off    <= lat_vel;
          end
        end
      end
    end
  end

`ifdef VOICE_STEAL_EN
  // Steal strobe accompanies note_on for exactly one cycle.
  always_ff @(posedge OSC_CLK) begin
    if (!reset_reg_N) voice_stolen <= 1'b0;
    else              voice_stolen <= !all_off && state == LOOKUP && sel_hit && sel_steal;
  end
`else
  assign voice_stolen = 1'b0;
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// Testbench for voice_allocator: directed note events, with an expected-queue
// scoreboard that is checked whenever the allocator presents an ISSUE cycle.
module tb_voice_allocator;

  localparam int W = 37;

  logic       OSC_CLK = 1'b0;
  logic       reset_reg_N = 1'b0;
  logic       ev_valid = 1'b0;
  logic       ev_ready;
  logic       ev_on = 1'b0;
  logic [7:0] ev_key = '0;
  logic [7:0] ev_vel = '0;
  logic       all_off = 1'b0;
  logic [7:0] voice_free = 8'hFF;
  logic [7:0] keys_on;
  logic       note_on;
  logic [2:0] cur_key_adr;
  logic [7:0] cur_key_val;
  logic [7:0] cur_vel_on;
  logic [7:0] cur_vel_off;
  logic       voice_stolen;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int snap;
  logic [W-1:0] exp_q[$];

  voice_allocator #(.VOICES(8), .V_WIDTH(3)) dut (
    .OSC_CLK(OSC_CLK), .reset_reg_N(reset_reg_N),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
    .ev_key(ev_key), .ev_vel(ev_vel), .all_off(all_off),
    .voice_free(voice_free), .keys_on(keys_on), .note_on(note_on),
    .cur_key_adr(cur_key_adr), .cur_key_val(cur_key_val),
    .cur_vel_on(cur_vel_on), .cur_vel_off(cur_vel_off),
    .voice_stolen(voice_stolen), .fsm_state(fsm_state)
  );

  // Clock and watchdog.
  always #5 OSC_CLK = ~OSC_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pk(input logic on, input logic [2:0] adr,
                                      input logic [7:0] key, input logic [7:0] von,
                                      input logic [7:0] voff, input logic [7:0] keys,
                                      input logic st);
    return {on, adr, key, von, voff, keys, st};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per ISSUE cycle. It also counts note_on strobes.
  always @(negedge OSC_CLK) begin
    if (reset_reg_N) begin
      if (note_on) strobe_cnt++;
      if (fsm_state == 2'd2) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: adr %0d key %0d with empty queue", cur_key_adr, cur_key_val);
        end else begin
          chk("issue_outputs",
              {27'd0, note_on, cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off, keys_on, voice_stolen},
              {27'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Driver: waits for ready (bounded), then presents one event for one handshake.
  // Returns at the negedge of the LOOKUP cycle.
  task automatic send(input logic on, input logic [7:0] key, input logic [7:0] vel);
    int n = 0;
    while (!ev_ready && n < 20) begin
      @(negedge OSC_CLK);
      n++;
    end
    chk("send_ready", ev_ready, 1);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_key   = key;
    ev_vel   = vel;
    @(posedge OSC_CLK);
    #1;
    ev_valid = 1'b0;
    @(negedge OSC_CLK);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(ev_ready && fsm_state == 2'd0) && n < 20) begin
      @(negedge OSC_CLK);
      n++;
    end
    chk("wait_idle", ev_ready, 1);
  endtask

  // Directed sequence.
  initial begin
    repeat (3) @(negedge OSC_CLK);
    reset_reg_N = 1'b1;
    @(negedge OSC_CLK);
    chk("reset_outputs",
        {note_on, cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off, keys_on, voice_stolen}, 0);
    chk("reset_ready_state", {ev_ready, fsm_state}, {1'b1, 2'd0});

    // 1: first note-on goes to voice 0; strobe at T+2, ready at T+3.
    exp_q.push_back(pk(1, 0, 60, 100, 0, 8'h01, 0));
    send(1, 60, 100);
    chk("t1_lookup_no_strobe", note_on, 0);
    @(negedge OSC_CLK);
    chk("t1_strobe_t2", note_on, 1);
    @(negedge OSC_CLK);
    chk("t1_ready_t3", ev_ready, 1);

    // 2: second voice, then a note-off releases voice 0 without a strobe.
    exp_q.push_back(pk(1, 1, 62, 90, 0, 8'h03, 0));
    send(1, 62, 90); wait_idle();
    snap = strobe_cnt;
    exp_q.push_back(pk(0, 0, 60, 90, 40, 8'h02, 0));
    send(0, 60, 40); wait_idle();
    chk("t2_off_no_strobe", strobe_cnt, snap);

    // 3: key 64 lands on voice 2, then retriggers there.
    exp_q.push_back(pk(1, 0, 61, 50, 40, 8'h03, 0));
    send(1, 61, 50); wait_idle();
    exp_q.push_back(pk(1, 2, 64, 70, 40, 8'h07, 0));
    send(1, 64, 70); wait_idle();
    exp_q.push_back(pk(1, 2, 64, 10, 40, 8'h07, 0));
    send(1, 64, 10); wait_idle();

    // 4: panic clear, fill all voices with keys 40..47, then overflow.
    all_off = 1'b1;
    @(negedge OSC_CLK);
    all_off = 1'b0;
    chk("t4_all_off_clear", keys_on, 0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(pk(1, 3'(i), 8'(40 + i), 100, 40, 8'((1 << (i + 1)) - 1), 0));
      send(1, 8'(40 + i), 100); wait_idle();
    end
    voice_free = 8'h00;
`ifdef VOICE_STEAL_EN
    exp_q.push_back(pk(1, 0, 50, 80, 40, 8'hFF, 1));
    send(1, 50, 80); wait_idle();
    exp_q.push_back(pk(0, 5, 45, 80, 0, 8'hDF, 0));
`else
    snap = strobe_cnt;
    send(1, 50, 80); wait_idle();
    chk("t4_drop_no_strobe", strobe_cnt, snap);
    chk("t4_drop_keys", keys_on, 8'hFF);
    chk("t4_drop_key_val", cur_key_val, 47);
    exp_q.push_back(pk(0, 5, 45, 100, 0, 8'hDF, 0));
`endif

    // 6: zero-velocity note-on acts as a note-off; an unheld note-off is dropped.
    send(1, 45, 0); wait_idle();
    snap = strobe_cnt;
    send(0, 99, 7); wait_idle();
    chk("t6_drop_keys", keys_on, 8'hDF);
    chk("t6_drop_no_strobe", strobe_cnt, snap);
    chk("t6_drop_key_val", cur_key_val, 45);
    chk("t6_drop_vel_off", cur_vel_off, 0);

    // 5: all_off during LOOKUP discards the event.
    voice_free = 8'hFF;
    snap = strobe_cnt;
    send(1, 70, 33);
    all_off = 1'b1;
    @(negedge OSC_CLK);
    chk("t5_keys_cleared", keys_on, 0);
    chk("t5_no_strobe", note_on, 0);
    chk("t5_ready_low", ev_ready, 0);
    all_off = 1'b0;
    @(negedge OSC_CLK);
    chk("t5_ready_after", ev_ready, 1);
    chk("t5_no_strobe_total", strobe_cnt, snap);
    chk("t5_key_val_kept", cur_key_val, 45);

    // After panic every voice is free again, so voice 0 is chosen.
    exp_q.push_back(pk(1, 0, 72, 20, 0, 8'h01, 0));
    send(1, 72, 20); wait_idle();

    repeat (3) @(negedge OSC_CLK);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
